// File: rtl/macro1_seq.sv
// macro1_seq: sequencer that drives the A/B/C inputs of a downstream macro1.
// Each accepted request runs the phases SETUP -> PULSE -> HOLD -> RELEASE.
// B/C are held stable around the A pulse, and Y is captured on the last
// PULSE cycle.
// Optional feature: define MACRO1_SEQ_YCHK_EN to enable a sticky Y-mismatch
// checker on err. When the macro is undefined, err is tied low.
module macro1_seq #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_valid,
   output logic start_ready,
   input  logic b_en,
   output logic a_o,
   output logic b_o,
   output logic c_o,
   input  logic y_i,
   output logic y_cap,
   output logic busy,
   output logic done,
   output logic err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      PULSE   = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   // The counter is loaded with (length - 1) and counts down to zero.
   // Legal lengths (1 .. 2**CNT_W-1) therefore never wrap.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             c_q, c_d;
   logic             y_cap_q, y_cap_d;
   logic             done_q, done_d;

   // Next-state logic.
   // A changes only on the SETUP->PULSE and PULSE->HOLD transitions.
   // B and C change only on the IDLE->SETUP and HOLD->RELEASE transitions.
   // As a result, A never toggles in the same cycle as B or C.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      y_cap_d = y_cap_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               state_d = SETUP;
               cnt_d   = SETUP_LD;
               c_d     = 1'b1;
               b_d     = b_en;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = PULSE;
               cnt_d   = PULSE_LD;
               a_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
               a_d     = 1'b0;
               y_cap_d = y_i;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = RELEASE;
               cnt_d   = '0;
               b_d     = 1'b0;
               c_d     = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            c_d     = 1'b0;
         end
      endcase
   end

   // State and output registers.
   // Reset aborts any sequence in flight immediately, without emitting done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         c_q     <= 1'b0;
         y_cap_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         y_cap_q <= y_cap_d;
         done_q  <= done_d;
      end
   end

`ifdef MACRO1_SEQ_YCHK_EN
   logic ben_q, ben_d;
   logic err_q, err_d;

   // Checker: latch b_en on accept.
   // Y is allowed one PULSE cycle to settle. On every later PULSE cycle,
   // flag a sticky error if Y differs from the latched b_en.
   always_comb begin
      ben_d = ben_q;
      err_d = err_q;
      if (state_q == IDLE && start_valid) begin
         ben_d = b_en;
      end
      if (state_q == PULSE && cnt_q != PULSE_LD && y_i != ben_q) begin
         err_d = 1'b1;
      end
   end

   // Checker registers.
   // The error flag is cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ben_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ben_q <= ben_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign a_o         = a_q;
   assign b_o         = b_q;
   assign c_o         = c_q;
   assign y_cap       = y_cap_q;
   assign done        = done_q;

endmodule

// File: tb/tb_macro1_seq.sv
// Directed testbench for macro1_seq with default parameters.
// The bench models macro1 as Y = A & B. A forcing input can pin Y low instead.
module tb_macro1_seq;

   logic clk = 1'b0;
   logic rst_n;
   logic start_valid;
   logic start_ready;
   logic b_en;
   logic a_o, b_o, c_o;
   logic y_i;
   logic y_cap;
   logic busy;
   logic done;
   logic err;
   logic y_force;

   int vectors     = 0;
   int miscompares = 0;
   logic exp_err   = 1'b0;

   always #5 clk = ~clk;

   // Behavioural model of the downstream macro1.
   assign y_i = y_force ? 1'b0 : (a_o & b_o);

   macro1_seq dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .b_en(b_en),
      .a_o(a_o),
      .b_o(b_o),
      .c_o(c_o),
      .y_i(y_i),
      .y_cap(y_cap),
      .busy(busy),
      .done(done),
      .err(err)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across two edges, then check every output's reset value.
   task automatic test_reset();
      logic [7:0] got;
      logic [7:0] exp;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      b_en        = 1'b0;
      y_force     = 1'b0;
      tick();
      tick();
      got = {a_o, b_o, c_o, y_cap, done, busy, err, start_ready};
      exp = 8'b0000_0001;
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %b expected %b", got, exp);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      exp_err = 1'b0;
   endtask

   // Run one full sequence and check each cycle from accept (cycle 0)
   // through the first IDLE cycle (cycle 10).
   task automatic test_full_sequence(input logic ben, input logic yf, input string tag);
      logic [5:0] got;
      logic [5:0] exp;
      logic       in_bc;
      for (int i = 0; i < 20 && start_ready !== 1'b1; i++) tick();
      vectors++;
      if (start_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s_ready_timeout: got %b expected 1", tag, start_ready);
      end
      b_en        = ben;
      y_force     = yf;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      b_en        = ~ben;
      for (int c = 1; c <= 10; c++) begin
         in_bc = (c >= 1 && c <= 8);
         exp = {(c >= 3 && c <= 6), ben & in_bc, in_bc, (c == 9), (c <= 9), (c == 10)};
         got = {a_o, b_o, c_o, done, busy, start_ready};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s_cycle%0d {a,b,c,done,busy,ready}: got %b expected %b",
                     tag, c, got, exp);
         end
         if (c >= 7) begin
            vectors++;
            if (y_cap !== (ben & ~yf)) begin
               miscompares++;
               $display("[TB] FAIL %s_ycap_cycle%0d: got %b expected %b", tag, c, y_cap, ben & ~yf);
            end
         end
         if (c < 10) tick();
      end
      vectors++;
      if (err !== exp_err) begin
         miscompares++;
         $display("[TB] FAIL %s_err: got %b expected %b", tag, err, exp_err);
      end
      y_force = 1'b0;
   endtask

   // Nominal sequence with b_en high: B pulses and Y = 1 is captured.
   task automatic test_b_en_high();
      test_full_sequence(1'b1, 1'b0, "ben1");
   endtask

   // Nominal sequence with b_en low: B stays low, C still pulses, Y = 0.
   task automatic test_b_en_low();
      test_full_sequence(1'b0, 1'b0, "ben0");
   endtask

   // With start_valid held high, accepts repeat every 10 cycles.
   // start_ready is high only in IDLE.
   task automatic test_back_to_back();
      logic [2:0] got;
      logic [2:0] exp;
      b_en        = 1'b1;
      start_valid = 1'b1;
      tick();
      for (int c = 1; c <= 30; c++) begin
         exp = {(c % 10 == 0), (c % 10 == 9), (c % 10 != 0)};
         got = {start_ready, done, busy};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL b2b_cycle%0d {ready,done,busy}: got %b expected %b", c, got, exp);
         end
         if (c == 30) start_valid = 1'b0;
         else tick();
      end
   endtask

   // Reset asserted mid-PULSE: outputs drop at once and no done appears.
   // The next request then runs a full sequence.
   task automatic test_reset_mid();
      logic [7:0] got;
      logic [7:0] exp;
      b_en        = 1'b1;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      tick();
      vectors++;
      if ({a_o, b_o, c_o} !== 3'b111) begin
         miscompares++;
         $display("[TB] FAIL rstmid_in_pulse {a,b,c}: got %b expected 111", {a_o, b_o, c_o});
      end
      #2;
      rst_n = 1'b0;
      #1;
      got = {a_o, b_o, c_o, y_cap, done, busy, err, start_ready};
      exp = 8'b0000_0001;
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL rstmid_async: got %b expected %b", got, exp);
      end
      exp_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_no_done: got %b expected 0", done);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_full_sequence(1'b1, 1'b0, "after_rst");
   endtask

   // Y forced low with b_en high.
   // The checker build flags a sticky err; the default build keeps err at 0.
   task automatic test_ychk();
`ifdef MACRO1_SEQ_YCHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      test_full_sequence(1'b1, 1'b1, "ychk");
      tick();
      vectors++;
      if (err !== exp_err) begin
         miscompares++;
         $display("[TB] FAIL ychk_sticky: got %b expected %b", err, exp_err);
      end
   endtask

   // Run every scenario in order, print the summary line, and finish.
   initial begin
      test_reset();
      test_b_en_high();
      test_b_en_low();
      test_back_to_back();
      test_reset_mid();
      test_ychk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
